// File: rtl/g3_pkg.sv
// Shared definitions for the G3 chain walker: widths, chain terminator,
// tuple field offsets and the walker state encoding.
package g3_pkg;

  localparam int INDEX_BIT_LEN    = 11;
  localparam int PACKET_BIT_LEN   = 104;
  localparam int ENTRY_DATA_WIDTH = 171;
  localparam int MAX_HOPS_DEFAULT = 16;

  localparam logic [INDEX_BIT_LEN-1:0] NULL_INDEX = '1;

  localparam int SRC_IP_LSB   = 0;
  localparam int DST_IP_LSB   = 32;
  localparam int SRC_PORT_LSB = 64;
  localparam int DST_PORT_LSB = 80;
  localparam int PROTO_LSB    = 96;

  typedef logic [INDEX_BIT_LEN-1:0]    index_t;
  typedef logic [PACKET_BIT_LEN-1:0]   tuple_t;
  typedef logic [ENTRY_DATA_WIDTH-1:0] entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_DONE,
    ST_WRITE
  } walk_state_e;

endpackage

// File: rtl/g3_chain_walker_if.sv
// Bundle of packet, write, table and result signals around the chain walker.
// The master modport is the walker's view; slave is the surrounding logic.
interface g3_chain_walker_if;
  import g3_pkg::*;

  logic   in_valid;
  logic   in_ready;
  tuple_t in_tuple;
  index_t in_start_index;

  logic   wr_valid;
  logic   wr_ready;
  index_t wr_index;
  entry_t wr_data;

  index_t tbl_search_index;
  tuple_t tbl_tuple;
  logic   tbl_we;
  entry_t tbl_din;
  logic   tbl_match;
  index_t tbl_ruleID;
  index_t tbl_next_index;

  logic   out_valid;
  logic   out_ready;
  logic   out_match;
  index_t out_ruleID;
  logic   out_trunc;

  modport master (
    input  in_valid, in_tuple, in_start_index,
    input  wr_valid, wr_index, wr_data,
    input  tbl_match, tbl_ruleID, tbl_next_index,
    input  out_ready,
    output in_ready, wr_ready,
    output tbl_search_index, tbl_tuple, tbl_we, tbl_din,
    output out_valid, out_match, out_ruleID, out_trunc
  );

  modport slave (
    output in_valid, in_tuple, in_start_index,
    output wr_valid, wr_index, wr_data,
    output tbl_match, tbl_ruleID, tbl_next_index,
    output out_ready,
    input  in_ready, wr_ready,
    input  tbl_search_index, tbl_tuple, tbl_we, tbl_din,
    input  out_valid, out_match, out_ruleID, out_trunc
  );

endinterface

// File: rtl/g3_chain_walker.sv
// Walks one linked G3 table chain per packet, keeping the lowest matching ruleID,
// and serialises rule writes against lookups. Optional stats: G3_WALK_STATS_EN.
module g3_chain_walker
  import g3_pkg::*;
#(
  parameter int MAX_HOPS = MAX_HOPS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  g3_chain_walker_if.master bus
`ifdef G3_WALK_STATS_EN
  ,
  output logic [$clog2(MAX_HOPS+1)-1:0] out_hops,
  output logic [31:0]                   stat_trunc_count
`endif
);

  localparam int HOP_W = $clog2(MAX_HOPS + 1);
  localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(MAX_HOPS - 1);

  walk_state_e      state_q, state_d;
  index_t           idx_q, idx_d;
  tuple_t           tuple_q, tuple_d;
  entry_t           din_q, din_d;
  logic [HOP_W-1:0] hops_q, hops_d;
  index_t           best_q, best_d;
  logic             trunc_q, trunc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= NULL_INDEX;
      tuple_q <= '0;
      din_q   <= '0;
      hops_q  <= '0;
      best_q  <= NULL_INDEX;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tuple_q <= tuple_d;
      din_q   <= din_d;
      hops_q  <= hops_d;
      best_q  <= best_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tuple_d = tuple_q;
    din_d   = din_q;
    hops_d  = hops_q;
    best_d  = best_q;
    trunc_d = trunc_q;

    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous write wins; the packet stays pending until IDLE returns.
        if (bus.wr_valid) begin
          state_d = ST_WRITE;
          idx_d   = bus.wr_index;
          din_d   = bus.wr_data;
        end else if (bus.in_valid) begin
          hops_d  = '0;
          best_d  = NULL_INDEX;
          trunc_d = 1'b0;
          if (bus.in_start_index == NULL_INDEX) begin
            state_d = ST_DONE;
          end else begin
            tuple_d = bus.in_tuple;
            idx_d   = bus.in_start_index;
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: state_d = ST_CHECK;
      ST_CHECK: begin
        if (bus.tbl_match && (bus.tbl_ruleID < best_q)) begin
          best_d = bus.tbl_ruleID;
        end
        hops_d = hops_q + HOP_W'(1);
        if (bus.tbl_next_index == NULL_INDEX) begin
          trunc_d = 1'b0;
          state_d = ST_DONE;
        end else if (hops_q == HOP_LAST) begin
          trunc_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = bus.tbl_next_index;
          state_d = ST_LOOKUP;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.wr_ready         = (state_q == ST_IDLE);
  assign bus.in_ready         = (state_q == ST_IDLE) && !bus.wr_valid;
  assign bus.tbl_search_index = idx_q;
  assign bus.tbl_tuple        = tuple_q;
  assign bus.tbl_we           = (state_q == ST_WRITE);
  assign bus.tbl_din          = din_q;
  assign bus.out_valid        = (state_q == ST_DONE);
  assign bus.out_match        = (state_q == ST_DONE) && (best_q != NULL_INDEX);
  assign bus.out_ruleID       = best_q;
  assign bus.out_trunc        = (state_q == ST_DONE) && trunc_q;

`ifdef G3_WALK_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] trunc_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trunc_cnt_q <= '0;
    end else if (bus.out_valid && bus.out_ready && trunc_q) begin
      trunc_cnt_q <= sat_inc32(trunc_cnt_q);
    end
  end

  assign out_hops         = hops_q;
  assign stat_trunc_count = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_g3_chain_walker.sv
// Directed bench for g3_chain_walker with a registered-read table model.
module tb_g3_chain_walker;
  import g3_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  g3_chain_walker_if bus ();

`ifdef G3_WALK_STATS_EN
  logic [$clog2(MAX_HOPS_DEFAULT+1)-1:0] out_hops;
  logic [31:0]                           stat_trunc_count;
  g3_chain_walker #(.MAX_HOPS(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .out_hops(out_hops), .stat_trunc_count(stat_trunc_count)
  );
`else
  g3_chain_walker #(.MAX_HOPS(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  logic   tm [2048];
  index_t tr [2048];
  index_t tn [2048];

  always @(posedge clk) begin
    bus.tbl_match      <= tm[bus.tbl_search_index];
    bus.tbl_ruleID     <= tr[bus.tbl_search_index];
    bus.tbl_next_index <= tn[bus.tbl_search_index];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
  endtask

  task automatic start_pkt(input tuple_t tup, input index_t si);
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_tuple = tup;
    bus.in_start_index = si;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  tuple_t tupA, tupB;
  entry_t wdat;
  int     lat;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      tm[i] = 1'b0;
      tr[i] = NULL_INDEX;
      tn[i] = NULL_INDEX;
    end
    tm[5] = 1'b0; tn[5] = 11'd9;
    tm[9] = 1'b1; tr[9] = 11'd42;  tn[9] = NULL_INDEX;
    tm[3] = 1'b1; tr[3] = 11'd20;  tn[3] = 11'd7;
    tm[7] = 1'b1; tr[7] = 11'd12;  tn[7] = NULL_INDEX;
    tm[4] = 1'b1; tr[4] = 11'd100; tn[4] = 11'd4;

    tupA = {8'd6, 16'd80, 16'd1234, 32'h0A00_0002, 32'h0A00_0001};
    tupB = {8'd17, 16'd53, 16'd999, 32'hC0A8_0001, 32'hC0A8_0064};
    wdat = {11'h155, 32'hDEAD_BEEF, tupB, 24'hABCDEF};

    bus.in_valid = 1'b0; bus.in_tuple = '0; bus.in_start_index = '0;
    bus.wr_valid = 1'b0; bus.wr_index = '0; bus.wr_data = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_match", bus.out_match, 1'b0);
    chk("rst_out_trunc", bus.out_trunc, 1'b0);
    chk("rst_tbl_we", bus.tbl_we, 1'b0);
    chk("rst_out_ruleID", bus.out_ruleID, 11'h7FF);
    chk("rst_tbl_idx", bus.tbl_search_index, 11'h7FF);
    chk("rst_tbl_tuple", bus.tbl_tuple, '0);
    chk("rst_tbl_din", bus.tbl_din, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1'b1);
    chk("idle_wr_ready", bus.wr_ready, 1'b1);

    // Chain 5 -> 9 -> NULL, only 9 matches
    start_pkt(tupA, 11'd5);
    wait_result(lat);
    chk("t1_latency", lat, 5);
    chk("t1_match", bus.out_match, 1'b1);
    chk("t1_rule", bus.out_ruleID, 11'd42);
    chk("t1_trunc", bus.out_trunc, 1'b0);
    chk("t1_tuple_held", bus.tbl_tuple, tupA);
    handshake();

    // Chain 3 -> 7 -> NULL, both match, later entry has lower rule
    start_pkt(tupB, 11'd3);
    wait_result(lat);
    chk("t2_latency", lat, 5);
    chk("t2_match", bus.out_match, 1'b1);
    chk("t2_rule", bus.out_ruleID, 11'd12);
    chk("t2_trunc", bus.out_trunc, 1'b0);
    handshake();

    // Empty bucket
    start_pkt(tupA, NULL_INDEX);
    wait_result(lat);
    chk("t3_latency", lat, 1);
    chk("t3_match", bus.out_match, 1'b0);
    chk("t3_rule", bus.out_ruleID, 11'h7FF);
    chk("t3_trunc", bus.out_trunc, 1'b0);
    chk("t3_idx_kept", bus.tbl_search_index, 11'd7);
    handshake();

    // Self-loop hits the hop limit after 16 visits
    start_pkt(tupB, 11'd4);
    wait_result(lat);
    chk("t4_latency", lat, 33);
    chk("t4_trunc", bus.out_trunc, 1'b1);
    chk("t4_match", bus.out_match, 1'b1);
    chk("t4_rule", bus.out_ruleID, 11'd100);
    handshake();

    // Write and packet in the same cycle: write first
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_index = 11'd12; bus.wr_data = wdat;
    bus.in_valid = 1'b1; bus.in_tuple = tupA; bus.in_start_index = 11'd5;
    #1;
    chk("t5_in_ready_blocked", bus.in_ready, 1'b0);
    chk("t5_wr_ready", bus.wr_ready, 1'b1);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t5_we", bus.tbl_we, 1'b1);
    chk("t5_wr_idx", bus.tbl_search_index, 11'd12);
    chk("t5_wr_din", bus.tbl_din, wdat);
    chk("t5_in_ready_write", bus.in_ready, 1'b0);
    chk("t5_wr_ready_write", bus.wr_ready, 1'b0);
    @(negedge clk);
    chk("t5_we_off", bus.tbl_we, 1'b0);
    chk("t5_in_ready_back", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(lat);
    chk("t5_latency", lat, 5);
    bus.in_valid = 1'b1; bus.in_tuple = tupB; bus.in_start_index = 11'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_stall_valid", bus.out_valid, 1'b1);
      chk("t5_stall_rule", bus.out_ruleID, 11'd42);
      chk("t5_stall_no_accept", bus.in_ready, 1'b0);
    end
    chk("t5_stall_tuple", bus.tbl_tuple, tupA);
    bus.in_valid = 1'b0;
    handshake();
    @(negedge clk);
    chk("t5_released", bus.out_valid, 1'b0);

    // Reset during CHECK drops the packet
    start_pkt(tupA, 11'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", bus.out_valid, 1'b0);
    chk("t6_we", bus.tbl_we, 1'b0);
    chk("t6_in_ready", bus.in_ready, 1'b1);
    chk("t6_idx", bus.tbl_search_index, 11'h7FF);
    chk("t6_tuple", bus.tbl_tuple, '0);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) lat++;
    end
    chk("t6_no_result", lat, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
